// File: rtl/gtp_link_pkg.sv
// Shared types, 8b/10b control constants and IDLE-word helpers for the GTP link controller.
package gtp_link_pkg;

  typedef enum logic [2:0] {
    RESET,
    WAIT_DONE,
    ALIGN,
    VERIFY,
    UP
  } lane_state_t;

  localparam logic [7:0] K28_5  = 8'hBC;
  localparam logic [7:0] D16_2  = 8'h50;
  localparam int         MAX_NB = 4;

  // IDLE is K28.5 in byte 0 followed by D16.2 fill; bytes at or above nb stay zero.
  function automatic logic [8*MAX_NB-1:0] idle_word(input int nb);
    logic [8*MAX_NB-1:0] w;
    w = '0;
    for (int b = 0; b < MAX_NB; b++) begin
      if (b < nb) w[b*8 +: 8] = (b == 0) ? K28_5 : D16_2;
    end
    return w;
  endfunction

  function automatic logic [MAX_NB-1:0] idle_k(input int nb);
    logic [MAX_NB-1:0] k;
    k = '0;
    for (int b = 0; b < MAX_NB; b++) begin
      k[b] = (b == 0) && (b < nb);
    end
    return k;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gtp_link_if.sv
// Bundle of all transceiver-side and fabric-side lane signals of the GTP link controller.
interface gtp_link_if #(
  parameter int LANES  = 1,
  parameter int DATA_W = 16
);
  localparam int NB = DATA_W / 8;

  logic [LANES-1:0]        gt_reset;
  logic [LANES-1:0]        gt_reset_done;
  logic [LANES-1:0]        rx_slide;
  logic [LANES*DATA_W-1:0] rx_data;
  logic [LANES*NB-1:0]     rx_is_k;
  logic [LANES*NB-1:0]     rx_code_err;
  logic [LANES*DATA_W-1:0] rx_user_data;
  logic [LANES-1:0]        rx_user_valid;
  logic [LANES*DATA_W-1:0] tx_user_data;
  logic [LANES-1:0]        tx_user_valid;
  logic [LANES*DATA_W-1:0] gt_tx_data;
  logic [LANES*NB-1:0]     gt_tx_is_k;
  logic [LANES-1:0]        lane_up;
  logic                    link_up;
  logic [LANES*16-1:0]     err_cnt;
  logic [LANES*8-1:0]      relock_cnt;

  modport master (
    output gt_reset, rx_slide, rx_user_data, rx_user_valid, gt_tx_data, gt_tx_is_k,
           lane_up, link_up, err_cnt, relock_cnt,
    input  gt_reset_done, rx_data, rx_is_k, rx_code_err, tx_user_data, tx_user_valid
  );

  modport slave (
    input  gt_reset, rx_slide, rx_user_data, rx_user_valid, gt_tx_data, gt_tx_is_k,
           lane_up, link_up, err_cnt, relock_cnt,
    output gt_reset_done, rx_data, rx_is_k, rx_code_err, tx_user_data, tx_user_valid
  );

endinterface

// File: rtl/gtp_link_ctrl_lane.sv
// One lane of the GTP link controller: reset/align/verify FSM, RX/TX registers.
// Optional statistics counters are built only with GTP_LINK_STATS_EN defined.
//
// state     | meaning
// RESET     | gt_reset asserted for RST_CYCLES
// WAIT_DONE | waiting for gt_reset_done, bounded by DONE_TIMEOUT
// ALIGN     | comma search, rx_slide pulses with SLIDE_GAP blanking
// VERIFY    | counting LOCK_CNT consecutive good words
// UP        | lane up, dropped after LOSS_CNT consecutive bad words
module gtp_lane_fsm
  import gtp_link_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int RST_CYCLES    = 256,
  parameter int DONE_TIMEOUT  = 65536,
  parameter int SLIDE_GAP     = 32,
  parameter int ALIGN_TIMEOUT = 8192,
  parameter int LOCK_CNT      = 64,
  parameter int LOSS_CNT      = 4,
  localparam int NB           = DATA_W / 8
) (
  input  logic              sysclk_i,
  input  logic              reset_n_i,
  output logic              gt_reset_o,
  input  logic              gt_reset_done_i,
  output logic              rx_slide_o,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic [NB-1:0]     rx_is_k_i,
  input  logic [NB-1:0]     rx_code_err_i,
  output logic [DATA_W-1:0] rx_user_data_o,
  output logic              rx_user_valid_o,
  input  logic [DATA_W-1:0] tx_user_data_i,
  input  logic              tx_user_valid_i,
  output logic [DATA_W-1:0] gt_tx_data_o,
  output logic [NB-1:0]     gt_tx_is_k_o,
  output logic              lane_up_o,
  output logic [15:0]       err_cnt_o,
  output logic [7:0]        relock_cnt_o
);

  localparam int T1   = (RST_CYCLES > DONE_TIMEOUT) ? RST_CYCLES : DONE_TIMEOUT;
  localparam int TMAX = (T1 > ALIGN_TIMEOUT) ? T1 : ALIGN_TIMEOUT;
  localparam int RMAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int TW   = cnt_w(TMAX);
  localparam int GW   = cnt_w(SLIDE_GAP);
  localparam int RW   = cnt_w(RMAX);

  localparam logic [TW-1:0] RST_TC   = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] DONE_TC  = TW'(DONE_TIMEOUT - 1);
  localparam logic [TW-1:0] ALIGN_TC = TW'(ALIGN_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_TC   = GW'(SLIDE_GAP - 1);
  localparam logic [RW-1:0] LOCK_TC  = RW'(LOCK_CNT - 1);
  localparam logic [RW-1:0] LOSS_TC  = RW'(LOSS_CNT - 1);

  localparam logic [8*MAX_NB-1:0] IDLE_FULL  = idle_word(NB);
  localparam logic [MAX_NB-1:0]   IDLE_KFULL = idle_k(NB);
  localparam logic [DATA_W-1:0]   IDLE_W     = IDLE_FULL[DATA_W-1:0];
  localparam logic [NB-1:0]       IDLE_K     = IDLE_KFULL[NB-1:0];

  lane_state_t       state_q;
  logic [TW-1:0]     tmr_q;
  logic [GW-1:0]     gap_q;
  logic              blank_q;
  logic [RW-1:0]     run_q;
  logic              gt_reset_q;
  logic              rx_slide_q;
  logic              lane_up_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [NB-1:0]     tx_k_q;

  logic [NB-1:0] comma;
  logic          comma0_ok;
  logic          other_comma;
  logic          good_word;

  always_comb begin
    comma = '0;
    for (int b = 0; b < NB; b++) begin
      comma[b] = rx_is_k_i[b] && (rx_data_i[b*8 +: 8] == K28_5);
    end
    other_comma = |comma[NB-1:1];
    comma0_ok   = comma[0] && !(|rx_code_err_i);
    good_word   = !(|rx_code_err_i) && !other_comma;
  end

  always_ff @(posedge sysclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= RESET;
      tmr_q      <= '0;
      gap_q      <= '0;
      blank_q    <= 1'b0;
      run_q      <= '0;
      gt_reset_q <= 1'b1;
      rx_slide_q <= 1'b0;
      lane_up_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_data_q  <= IDLE_W;
      tx_k_q     <= IDLE_K;
    end else begin
      rx_slide_q <= 1'b0;
      rx_data_q  <= rx_data_i;
      rx_valid_q <= lane_up_q && !rx_is_k_i[0];
      if (lane_up_q && tx_user_valid_i) begin
        tx_data_q <= tx_user_data_i;
        tx_k_q    <= '0;
      end else begin
        tx_data_q <= IDLE_W;
        tx_k_q    <= IDLE_K;
      end

      case (state_q)
        RESET: begin
          if (tmr_q == RST_TC) begin
            state_q    <= WAIT_DONE;
            tmr_q      <= '0;
            gt_reset_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end

        WAIT_DONE: begin
          if (tmr_q == DONE_TC) begin
            state_q    <= RESET;
            tmr_q      <= '0;
            gt_reset_q <= 1'b1;
          end else if (gt_reset_done_i) begin
            state_q <= ALIGN;
            tmr_q   <= '0;
            gap_q   <= '0;
            blank_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end

        ALIGN, VERIFY, UP: begin
          if (!gt_reset_done_i) begin
            state_q   <= WAIT_DONE;
            tmr_q     <= '0;
            run_q     <= '0;
            lane_up_q <= 1'b0;
          end else if (state_q == ALIGN) begin
            // Timeout is checked before the comma so it wins a same-cycle tie.
            if (tmr_q == ALIGN_TC) begin
              state_q    <= RESET;
              tmr_q      <= '0;
              gt_reset_q <= 1'b1;
            end else begin
              tmr_q <= tmr_q + 1'b1;
              if (blank_q) begin
                if (gap_q == GAP_TC) begin
                  blank_q <= 1'b0;
                  gap_q   <= '0;
                end else begin
                  gap_q <= gap_q + 1'b1;
                end
              end else if (comma0_ok) begin
                state_q <= VERIFY;
                run_q   <= '0;
              end else if (other_comma || gap_q == GAP_TC) begin
                rx_slide_q <= 1'b1;
                blank_q    <= 1'b1;
                gap_q      <= '0;
              end else begin
                gap_q <= gap_q + 1'b1;
              end
            end
          end else if (state_q == VERIFY) begin
            if (!good_word) begin
              state_q <= ALIGN;
              run_q   <= '0;
              tmr_q   <= '0;
              gap_q   <= '0;
              blank_q <= 1'b0;
            end else if (run_q == LOCK_TC) begin
              state_q   <= UP;
              run_q     <= '0;
              lane_up_q <= 1'b1;
            end else begin
              run_q <= run_q + 1'b1;
            end
          end else begin
            if (good_word) begin
              run_q <= '0;
            end else if (run_q == LOSS_TC) begin
              state_q   <= ALIGN;
              run_q     <= '0;
              tmr_q     <= '0;
              gap_q     <= '0;
              blank_q   <= 1'b0;
              lane_up_q <= 1'b0;
            end else begin
              run_q <= run_q + 1'b1;
            end
          end
        end

        default: begin
          state_q    <= RESET;
          tmr_q      <= '0;
          gt_reset_q <= 1'b1;
          lane_up_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GTP_LINK_STATS_EN
  logic [15:0] err_q;
  logic [7:0]  relock_q;
  logic        bad_evt;
  logic        relock_evt;

  assign bad_evt    = gt_reset_done_i && (state_q == VERIFY || state_q == UP) && !good_word;
  assign relock_evt = bad_evt && (state_q == UP) && (run_q == LOSS_TC);

  always_ff @(posedge sysclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_q    <= '0;
      relock_q <= '0;
    end else begin
      if (bad_evt && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
      if (relock_evt && relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
    end
  end

  assign err_cnt_o    = err_q;
  assign relock_cnt_o = relock_q;
`else
  assign err_cnt_o    = '0;
  assign relock_cnt_o = '0;
`endif

  assign gt_reset_o      = gt_reset_q;
  assign rx_slide_o      = rx_slide_q;
  assign lane_up_o       = lane_up_q;
  assign rx_user_data_o  = rx_data_q;
  assign rx_user_valid_o = rx_valid_q;
  assign gt_tx_data_o    = tx_data_q;
  assign gt_tx_is_k_o    = tx_k_q;

endmodule

// File: rtl/gtp_link_ctrl.sv
// Multi-lane GTP link controller top: one gtp_lane_fsm per lane plus the link_up AND.
// Lane statistics are present only when GTP_LINK_STATS_EN is defined.
module gtp_link_ctrl
  import gtp_link_pkg::*;
#(
  parameter int LANES         = 1,
  parameter int DATA_W        = 16,
  parameter int RST_CYCLES    = 256,
  parameter int DONE_TIMEOUT  = 65536,
  parameter int SLIDE_GAP     = 32,
  parameter int ALIGN_TIMEOUT = 8192,
  parameter int LOCK_CNT      = 64,
  parameter int LOSS_CNT      = 4
) (
  input  logic     sysclk,
  input  logic     reset_n,
  gtp_link_if.master lnk
);

  localparam int NB = DATA_W / 8;

  logic [LANES-1:0]        gt_reset_w;
  logic [LANES-1:0]        rx_slide_w;
  logic [LANES-1:0]        rx_valid_w;
  logic [LANES-1:0]        lane_up_w;
  logic [LANES*DATA_W-1:0] rx_data_w;
  logic [LANES*DATA_W-1:0] tx_data_w;
  logic [LANES*NB-1:0]     tx_k_w;
  logic [LANES*16-1:0]     err_w;
  logic [LANES*8-1:0]      relock_w;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gtp_lane_fsm #(
      .DATA_W       (DATA_W),
      .RST_CYCLES   (RST_CYCLES),
      .DONE_TIMEOUT (DONE_TIMEOUT),
      .SLIDE_GAP    (SLIDE_GAP),
      .ALIGN_TIMEOUT(ALIGN_TIMEOUT),
      .LOCK_CNT     (LOCK_CNT),
      .LOSS_CNT     (LOSS_CNT)
    ) u_lane (
      .sysclk_i       (sysclk),
      .reset_n_i      (reset_n),
      .gt_reset_o     (gt_reset_w[i]),
      .gt_reset_done_i(lnk.gt_reset_done[i]),
      .rx_slide_o     (rx_slide_w[i]),
      .rx_data_i      (lnk.rx_data[i*DATA_W +: DATA_W]),
      .rx_is_k_i      (lnk.rx_is_k[i*NB +: NB]),
      .rx_code_err_i  (lnk.rx_code_err[i*NB +: NB]),
      .rx_user_data_o (rx_data_w[i*DATA_W +: DATA_W]),
      .rx_user_valid_o(rx_valid_w[i]),
      .tx_user_data_i (lnk.tx_user_data[i*DATA_W +: DATA_W]),
      .tx_user_valid_i(lnk.tx_user_valid[i]),
      .gt_tx_data_o   (tx_data_w[i*DATA_W +: DATA_W]),
      .gt_tx_is_k_o   (tx_k_w[i*NB +: NB]),
      .lane_up_o      (lane_up_w[i]),
      .err_cnt_o      (err_w[i*16 +: 16]),
      .relock_cnt_o   (relock_w[i*8 +: 8])
    );
  end

  assign lnk.gt_reset      = gt_reset_w;
  assign lnk.rx_slide      = rx_slide_w;
  assign lnk.rx_user_data  = rx_data_w;
  assign lnk.rx_user_valid = rx_valid_w;
  assign lnk.gt_tx_data    = tx_data_w;
  assign lnk.gt_tx_is_k    = tx_k_w;
  assign lnk.lane_up       = lane_up_w;
  assign lnk.link_up       = &lane_up_w;
  assign lnk.err_cnt       = err_w;
  assign lnk.relock_cnt    = relock_w;

endmodule

// File: tb/tb_gtp_link_ctrl.sv
// Directed bench for gtp_link_ctrl: single 16-bit lane (short DONE_TIMEOUT) and a 2x32-bit link.
module tb_gtp_link_ctrl;

  logic clk;
  logic rst1_n;
  logic rst2_n;

  int checks = 0;
  int errors = 0;

  gtp_link_if #(.LANES(1), .DATA_W(16)) l1 ();
  gtp_link_if #(.LANES(2), .DATA_W(32)) l2 ();

  gtp_link_ctrl #(
    .LANES(1), .DATA_W(16), .DONE_TIMEOUT(4096)
  ) u_dut1 (
    .sysclk (clk),
    .reset_n(rst1_n),
    .lnk    (l1)
  );

  gtp_link_ctrl #(
    .LANES(2), .DATA_W(32)
  ) u_dut2 (
    .sysclk (clk),
    .reset_n(rst2_n),
    .lnk    (l2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int n;
  int bad;
  int sl;

  initial begin
    rst1_n = 1'b0;
    rst2_n = 1'b0;
    l1.gt_reset_done = 1'b0;
    l1.rx_data       = 16'h0000;
    l1.rx_is_k       = 2'b00;
    l1.rx_code_err   = 2'b00;
    l1.tx_user_data  = 16'h1234;
    l1.tx_user_valid = 1'b1;
    l2.gt_reset_done = 2'b11;
    l2.rx_data       = {32'h50BC5050, 32'h505050BC};
    l2.rx_is_k       = {4'b0100, 4'b0001};
    l2.rx_code_err   = 8'h00;
    l2.tx_user_data  = 64'h0;
    l2.tx_user_valid = 2'b00;

    repeat (3) @(negedge clk);
    chk("rst_gt_reset",   l1.gt_reset, 1'b1);
    chk("rst_rx_slide",   l1.rx_slide, 1'b0);
    chk("rst_lane_up",    l1.lane_up, 1'b0);
    chk("rst_link_up",    l1.link_up, 1'b0);
    chk("rst_rx_valid",   l1.rx_user_valid, 1'b0);
    chk("rst_rx_data",    l1.rx_user_data, 16'h0000);
    chk("rst_err_cnt",    l1.err_cnt, 16'h0000);
    chk("rst_relock_cnt", l1.relock_cnt, 8'h00);
    chk("rst_tx_data",    l1.gt_tx_data, 16'h50BC);
    chk("rst_tx_k",       l1.gt_tx_is_k, 2'b01);
    chk("rst2_tx_data",   l2.gt_tx_data, {2{32'h505050BC}});
    chk("rst2_tx_k",      l2.gt_tx_is_k, 8'h11);

    // Reset pulse width after release, with TX idle throughout.
    rst1_n = 1'b1;
    n = 0;
    bad = 0;
    while (l1.gt_reset[0] && n < 1000) begin
      if (l1.gt_tx_data !== 16'h50BC || l1.gt_tx_is_k !== 2'b01) bad++;
      @(negedge clk);
      n++;
    end
    chk("reset_pulse_width", n, 256);
    l1.rx_data = 16'hBC50;
    l1.rx_is_k = 2'b10;
    repeat (100) begin
      if (l1.gt_reset[0] !== 1'b0) bad++;
      if (l1.gt_tx_data !== 16'h50BC || l1.gt_tx_is_k !== 2'b01) bad++;
      @(negedge clk);
    end
    chk("idle_and_no_reset_in_wait", bad, 0);
    l1.gt_reset_done = 1'b1;

    // Comma in byte 1: first slide on the first ALIGN search cycle, then every 33.
    n = 0;
    while (!l1.rx_slide[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_slide_latency", n, 2);
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      chk("slide_width", l1.rx_slide, 1'b0);
      n = 1;
      while (!l1.rx_slide[0] && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("slide_period", n, 33);
    end

    // Comma moved to byte 0 right after a slide: 32 blank + 1 align + 64 verify.
    l1.rx_data = 16'h50BC;
    l1.rx_is_k = 2'b01;
    n = 0;
    sl = 0;
    while (!l1.lane_up[0] && n < 300) begin
      @(negedge clk);
      n++;
      if (l1.rx_slide[0]) sl++;
    end
    chk("lane_up_latency", n, 97);
    chk("no_slide_when_aligned", sl, 0);
    chk("link_up_single", l1.link_up, 1'b1);

    // RX path.
    l1.rx_data = 16'hABCD;
    l1.rx_is_k = 2'b00;
    @(negedge clk);
    chk("rx_data_abcd", l1.rx_user_data, 16'hABCD);
    chk("rx_valid_data", l1.rx_user_valid, 1'b1);
    l1.rx_data = 16'h50BC;
    l1.rx_is_k = 2'b01;
    @(negedge clk);
    chk("rx_data_idle", l1.rx_user_data, 16'h50BC);
    chk("rx_valid_idle", l1.rx_user_valid, 1'b0);

    // TX mux.
    chk("tx_user_1234", l1.gt_tx_data, 16'h1234);
    chk("tx_user_k", l1.gt_tx_is_k, 2'b00);
    l1.tx_user_valid = 1'b0;
    @(negedge clk);
    chk("tx_idle_data", l1.gt_tx_data, 16'h50BC);
    chk("tx_idle_k", l1.gt_tx_is_k, 2'b01);
    l1.tx_user_valid = 1'b1;
    l1.tx_user_data  = 16'h5A5A;
    @(negedge clk);
    chk("tx_user_5a5a", l1.gt_tx_data, 16'h5A5A);

    // Loss of lock: 3 bad words tolerated, 4 drop the lane.
    l1.rx_code_err = 2'b01;
    repeat (3) @(negedge clk);
    chk("up_after_3_bad", l1.lane_up, 1'b1);
    l1.rx_code_err = 2'b00;
    @(negedge clk);
    chk("up_after_good", l1.lane_up, 1'b1);
    l1.rx_code_err = 2'b01;
    repeat (3) @(negedge clk);
    chk("up_before_4th_bad", l1.lane_up, 1'b1);
    @(negedge clk);
    chk("down_after_4th_bad", l1.lane_up, 1'b0);
    chk("link_down_after_loss", l1.link_up, 1'b0);
`ifdef GTP_LINK_STATS_EN
    chk("relock_cnt", l1.relock_cnt, 8'd1);
    chk("err_cnt", l1.err_cnt, 16'd7);
`else
    chk("relock_cnt", l1.relock_cnt, 8'd0);
    chk("err_cnt", l1.err_cnt, 16'd0);
`endif
    l1.rx_code_err = 2'b00;

    // Relock from ALIGN: 1 align + 64 verify.
    n = 0;
    while (!l1.lane_up[0] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("relock_latency", n, 65);

    // gt_reset_done drop in UP, then WAIT_DONE timeout and reset re-pulse.
    l1.gt_reset_done = 1'b0;
    n = 0;
    while (!l1.gt_reset[0] && n < 10000) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("lane_down_on_done_drop", l1.lane_up, 1'b0);
    end
    chk("done_drop_to_repulse", n, 4097);
    n = 0;
    while (l1.gt_reset[0] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("repulse_width", n, 256);
    n = 0;
    while (!l1.gt_reset[0] && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done_timeout", n, 4096);

    // ALIGN timeout with no commas.
    n = 0;
    while (l1.gt_reset[0] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    l1.rx_data = 16'h0000;
    l1.rx_is_k = 2'b00;
    l1.gt_reset_done = 1'b1;
    n = 0;
    sl = 0;
    while (!l1.gt_reset[0] && n < 20000) begin
      @(negedge clk);
      n++;
      if (l1.rx_slide[0]) sl++;
    end
    chk("align_timeout", n, 8193);
    chk("align_timeout_slides", sl, 128);

    // Two-lane link: lane 1 has its comma in byte 2.
    rst2_n = 1'b1;
    n = 0;
    while (l2.lane_up !== 2'b01 && n < 800) begin
      @(negedge clk);
      n++;
    end
    chk("ml_lane_up_01", l2.lane_up, 2'b01);
    chk("ml_link_down", l2.link_up, 1'b0);
    repeat (100) @(negedge clk);
    chk("ml_lane1_stays_down", l2.lane_up, 2'b01);
    l2.rx_data = {32'h505050BC, 32'h505050BC};
    l2.rx_is_k = {4'b0001, 4'b0001};
    n = 0;
    while (!l2.link_up && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ml_lane_up_11", l2.lane_up, 2'b11);
    chk("ml_link_up", l2.link_up, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
